// File: rtl/d_flip_flop.sv
// Parameterizable D-type register chain: STAGES cascaded WIDTH-bit registers
// with asynchronous active-high reset to RST_VAL; latency equals STAGES.
module d_flip_flop #(
    parameter int                WIDTH   = 1,
    parameter int                STAGES  = 1,
    parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Each stage owns its register so every stage is its own always block,
    // and stage i feeds from stage i-1 (stage 0 feeds from d).
    for (genvar i = 0; i < STAGES; i++) begin : gen_stage
        logic [WIDTH-1:0] stage_d;
        logic [WIDTH-1:0] stage_q;

        if (i == 0) begin : gen_head
            assign stage_d = d;
        end else begin : gen_tail
            assign stage_d = gen_stage[i-1].stage_q;
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                stage_q <= RST_VAL;
            end else begin
                stage_q <= stage_d;
            end
        end
    end

    assign q = gen_stage[STAGES-1].stage_q;

endmodule

// File: tb/tb_d_flip_flop.sv
// Directed bench for d_flip_flop: a default 1-bit/1-stage instance and an
// 8-bit/3-stage instance resetting to 8'hA5, checked against hand-computed values.
`timescale 1ns/1ps
module tb_d_flip_flop;

    logic       clk;
    logic       rst;
    logic       d;
    logic       q;

    logic       rst2;
    logic [7:0] d2;
    logic [7:0] q2;

    int assertCount = 0;
    int failCount   = 0;

    d_flip_flop dutDefault (
        .clk (clk),
        .rst (rst),
        .d   (d),
        .q   (q)
    );

    d_flip_flop #(
        .WIDTH   (8),
        .STAGES  (3),
        .RST_VAL (8'hA5)
    ) dutWide (
        .clk (clk),
        .rst (rst2),
        .d   (d2),
        .q   (q2)
    );

    // Rising edges at 5, 15, 25, ... ns.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [7:0] observed,
                               input logic [7:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic waitUntil(input int t);
        #(t - int'($time));
    endtask

    initial begin
        rst  = 1'b1;
        d    = 1'b0;
        rst2 = 1'b1;
        d2   = 8'h00;

        waitUntil(1);
        checkOutput("reset_t0", {7'b0, q}, 8'h00);
        checkOutput("wide_reset_t0", q2, 8'hA5);
        waitUntil(6);
        checkOutput("reset_hold_edge5", {7'b0, q}, 8'h00);

        waitUntil(10);
        rst = 1'b0;
        d   = 1'b0;
        waitUntil(16);
        checkOutput("zero_capture", {7'b0, q}, 8'h00);

        waitUntil(20); d = 1'b1;
        waitUntil(26); checkOutput("toggle_1", {7'b0, q}, 8'h01);
        waitUntil(30); d = 1'b0;
        waitUntil(36); checkOutput("toggle_0", {7'b0, q}, 8'h00);
        waitUntil(40); d = 1'b1;
        waitUntil(46); checkOutput("toggle_1b", {7'b0, q}, 8'h01);

        // Asynchronous reset between edges 45 and 55.
        waitUntil(47); rst = 1'b1;
        waitUntil(48); checkOutput("async_reset", {7'b0, q}, 8'h00);
        waitUntil(50); d = 1'b0;
        waitUntil(52); rst = 1'b0;
        waitUntil(56); checkOutput("post_reset_edge55", {7'b0, q}, 8'h00);

        // d wiggles between edges 55 and 65; q must not follow until 65.
        waitUntil(57); d = 1'b1;
        waitUntil(58); d = 1'b0;
        waitUntil(59); d = 1'b1;
        waitUntil(60); checkOutput("hold_mid_a", {7'b0, q}, 8'h00);
        waitUntil(61); d = 1'b0;
        waitUntil(62); d = 1'b1;
        waitUntil(63); checkOutput("hold_mid_b", {7'b0, q}, 8'h00);
        waitUntil(66); checkOutput("hold_edge65", {7'b0, q}, 8'h01);
        waitUntil(86); checkOutput("hold_until_end", {7'b0, q}, 8'h01);

        // Wide instance: release at 100, then feed 01, 02, 03 on successive edges.
        waitUntil(100); rst2 = 1'b0; d2 = 8'h01;
        waitUntil(106); checkOutput("wide_edge1", q2, 8'hA5);
        waitUntil(110); d2 = 8'h02;
        waitUntil(116); checkOutput("wide_edge2", q2, 8'hA5);
        waitUntil(120); d2 = 8'h03;
        waitUntil(126); checkOutput("wide_out_01", q2, 8'h01);
        waitUntil(130); d2 = 8'h04;
        waitUntil(136); checkOutput("wide_out_02", q2, 8'h02);
        waitUntil(146); checkOutput("wide_out_03", q2, 8'h03);

        // Mid-stream reset flushes all three stages.
        waitUntil(147); rst2 = 1'b1;
        waitUntil(148); checkOutput("wide_async_reset", q2, 8'hA5);
        waitUntil(150); rst2 = 1'b0; d2 = 8'hFF;
        waitUntil(156); checkOutput("wide_flush_1", q2, 8'hA5);
        waitUntil(166); checkOutput("wide_flush_2", q2, 8'hA5);
        waitUntil(176); checkOutput("wide_refill", q2, 8'hFF);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
